// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth limits, fill-width helper
// and status-register flag bit positions.
package fifo_pkg;

  localparam int FIFO_MAX_DEPTH_LOG2 = 12;

  localparam int FLAG_NEMPTY = 0;
  localparam int FLAG_FULL   = 1;
  localparam int FLAG_AF     = 2;
  localparam int FLAG_AE     = 3;
  localparam int FLAG_OVF    = 4;
  localparam int FLAG_UDF    = 5;
  localparam int FLAG_COUNT  = 6;

  // Bits needed to count 0..2**depth_log2 inclusive.
  function automatic int fill_width(input int depth_log2);
    return $clog2((1 << depth_log2) + 1);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one synchronous write port and one
// synchronous read port with an enable-gated output register.
module fifo_ram_sdp #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Storage array, written on accepted writes only.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_same_clock_fwft.sv
// Single-clock first-word-fall-through FIFO with thresholds,
// fill count, flush and sticky errors. Option: FIFO_SAME_CLOCK_FWFT_HWM_EN.
module fifo_same_clock_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  nempty,
  output logic                  full,
  input  logic [DATA_DEPTH:0]   af_thresh,
  input  logic [DATA_DEPTH:0]   ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DATA_DEPTH:0]   fill,
  input  logic                  clr_err,
  output logic                  overflow,
`ifdef FIFO_SAME_CLOCK_FWFT_HWM_EN
  output logic                  underflow,
  output logic [DATA_DEPTH:0]   hwm
`else
  output logic                  underflow
`endif
);

  localparam int FW = fill_width(DATA_DEPTH);
  localparam logic [FW-1:0] CAP = FW'(1 << DATA_DEPTH);

  logic [DATA_DEPTH-1:0] wr_ptr;
  logic [DATA_DEPTH-1:0] rd_ptr;
  logic [DATA_DEPTH-1:0] rd_ptr_nxt;
  logic [FW-1:0]         fill_q;
  logic [FW-1:0]         fill_pop;
  logic [FW-1:0]         fill_nxt;
  logic                  wa_ok;
  logic                  re_ok;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  hd_en;
  logic                  byp_sel;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [DATA_WIDTH-1:0] ram_q;

  // Accept/reject decisions and next occupancy.
  always_comb begin
    re_ok      = re & nempty & ~flush;
    wa_ok      = we & (~full | re_ok) & ~flush;
    ovf_evt    = we & full & ~re_ok & ~flush;
    udf_evt    = re & ~nempty & ~flush;
    fill_pop   = fill_q - FW'(re_ok);
    fill_nxt   = flush ? '0 : fill_pop + FW'(wa_ok);
    rd_ptr_nxt = flush ? '0 : rd_ptr + DATA_DEPTH'(re_ok);
    hd_en      = (fill_nxt != '0);
  end

  // Prefetch the next head so it is ready one cycle later.
  fifo_ram_sdp #(
    .W  (DATA_WIDTH),
    .AW (DATA_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wa_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (hd_en),
    .raddr (rd_ptr_nxt),
    .rdata (ram_q)
  );

  // Pointers and fill counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      fill_q <= fill_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (flush)      wr_ptr <= '0;
      else if (wa_ok) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // A word written into an otherwise-empty FIFO bypasses the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else if (hd_en) begin
      byp_sel  <= wa_ok & (fill_pop == '0);
      byp_data <= data_in;
    end
  end

  assign data_out = byp_sel ? byp_data : ram_q;
  assign fill     = fill_q;

  // Status flags registered from the next fill value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nempty       <= 1'b0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      nempty       <= (fill_nxt != '0);
      full         <= (fill_nxt == CAP);
      almost_full  <= (fill_nxt >= af_thresh);
      almost_empty <= (fill_nxt <= ae_thresh);
    end
  end

  // Sticky errors; a new event wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= udf_evt | (underflow & ~clr_err);
    end
  end

`ifdef FIFO_SAME_CLOCK_FWFT_HWM_EN
  // Peak occupancy since reset, flush or error clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  hwm <= '0;
    else if (flush | clr_err) hwm <= fill_nxt;
    else if (fill_nxt > hwm)  hwm <= fill_nxt;
  end
`endif

endmodule

// File: tb/tb_fifo_same_clock_fwft.sv
// Testbench for fifo_same_clock_fwft: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_fifo_same_clock_fwft;

  localparam int DW  = 16;
  localparam int DD  = 4;
  localparam int CAP = 1 << DD;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          we;
  logic [DW-1:0] data_in;
  logic          re;
  logic [DW-1:0] data_out;
  logic          nempty;
  logic          full;
  logic [DD:0]   af_thresh;
  logic [DD:0]   ae_thresh;
  logic          almost_full;
  logic          almost_empty;
  logic [DD:0]   fill;
  logic          clr_err;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_SAME_CLOCK_FWFT_HWM_EN
  logic [DD:0]   hwm;
`endif

  fifo_same_clock_fwft #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .we           (we),
    .data_in      (data_in),
    .re           (re),
    .data_out     (data_out),
    .nempty       (nempty),
    .full         (full),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill         (fill),
    .clr_err      (clr_err),
    .overflow     (overflow),
`ifdef FIFO_SAME_CLOCK_FWFT_HWM_EN
    .underflow    (underflow),
    .hwm          (hwm)
`else
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  logic [DW-1:0] mq [$];
  bit m_ovf;
  bit m_udf;
  int m_hwm;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h",
             phase, tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_fill",   32'(fill), 0);
    chk("rst_nempty", 32'(nempty), 0);
    chk("rst_full",   32'(full), 0);
    chk("rst_af",     32'(almost_full), 0);
    chk("rst_ae",     32'(almost_empty), 1);
    chk("rst_ovf",    32'(overflow), 0);
    chk("rst_udf",    32'(underflow), 0);
    chk("rst_dout",   32'(data_out), 0);
`ifdef FIFO_SAME_CLOCK_FWFT_HWM_EN
    chk("rst_hwm",    32'(hwm), 0);
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    m_hwm = 0;
  endtask

  task automatic chk_all();
    int n;
    n = mq.size();
    chk("fill",   32'(fill), 32'(n));
    chk("nempty", 32'(nempty), 32'(n > 0));
    chk("full",   32'(full), 32'(n == CAP));
    chk("af",     32'(almost_full), 32'(n >= int'(af_thresh)));
    chk("ae",     32'(almost_empty), 32'(n <= int'(ae_thresh)));
    chk("ovf",    32'(overflow), 32'(m_ovf));
    chk("udf",    32'(underflow), 32'(m_udf));
    if (n > 0) chk("dout", 32'(data_out), 32'(mq[0]));
`ifdef FIFO_SAME_CLOCK_FWFT_HWM_EN
    chk("hwm",    32'(hwm), 32'(m_hwm));
`endif
  endtask

  // One clock: drive, clock, update model, compare.
  task automatic step(input bit w, input logic [DW-1:0] d,
                      input bit r, input bit fl, input bit ce);
    bit pop, push, oe, ue;
    we = w; data_in = d; re = r; flush = fl; clr_err = ce;
    @(posedge clk);
    #1;
    pop = 0; push = 0; oe = 0; ue = 0;
    if (fl) begin
      mq.delete();
    end else begin
      pop  = r && mq.size() > 0;
      push = w && (mq.size() < CAP || pop);
      oe   = w && mq.size() == CAP && !pop;
      ue   = r && mq.size() == 0;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    m_ovf = oe || (m_ovf && !ce);
    m_udf = ue || (m_udf && !ce);
    if (fl || ce) m_hwm = mq.size();
    else if (mq.size() > m_hwm) m_hwm = mq.size();
    chk_all();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0);
  endtask

  initial begin
    logic [DW-1:0] nxt;
    rst = 1; flush = 0; we = 0; re = 0; clr_err = 0;
    data_in = '0; af_thresh = 5'd12; ae_thresh = 5'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    chk_reset();
    rst = 0;

    phase = "latency";
    step(1, 16'hABCD, 0, 0, 0);
    chk("lat_dout", 32'(data_out), 32'hABCD);
    step(0, '0, 1, 0, 0);
    chk("lat_empty", 32'(nempty), 0);

    phase = "fill16";
    for (int i = 1; i <= CAP; i++) step(1, DW'(i), 0, 0, 0);
    chk("full16", 32'(full), 1);
    step(1, 16'hDEAD, 0, 0, 0);
    chk("ovf17", 32'(overflow), 1);
    chk("fill17", 32'(fill), 32'(CAP));

    phase = "fullrw";
    nxt = 16'h0100;
    for (int i = 0; i < 40; i++) begin
      step(1, nxt, 1, 0, 0);
      nxt++;
    end

    phase = "thresh";
    step(0, '0, 0, 0, 1);
    while (mq.size() > 0) step(0, '0, 1, 0, 0);
    for (int i = 0; i < CAP; i++) step(1, DW'($urandom), 0, 0, 0);
    for (int i = 0; i < CAP; i++) step(0, '0, 1, 0, 0);

    phase = "underflow";
    step(0, '0, 1, 0, 0);
    chk("udf_set", 32'(underflow), 1);
    step(0, '0, 1, 0, 1);
    chk("udf_hold", 32'(underflow), 1);
    step(0, '0, 0, 0, 1);
    chk("udf_clr", 32'(underflow), 0);
    step(1, 16'h5A5A, 1, 0, 0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        af_thresh = 5'($urandom_range(0, CAP));
        ae_thresh = 5'($urandom_range(0, CAP));
      end
      step($urandom_range(0, 99) < 55, DW'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 4);
    end

    phase = "flush";
    af_thresh = 5'd12; ae_thresh = 5'd3;
    step(0, '0, 0, 1, 1);
    for (int i = 0; i < 9; i++) step(1, DW'(16'h0900 + i), 0, 0, 0);
    chk("fill9", 32'(fill), 9);
    step(1, 16'hFFFF, 1, 1, 0);
    chk("fl_fill", 32'(fill), 0);
    chk("fl_nempty", 32'(nempty), 0);
    af_thresh = 5'd0;
    step(0, '0, 0, 1, 0);
    chk("fl_af0", 32'(almost_full), 1);
    af_thresh = 5'd12;

    phase = "asyncrst";
    for (int i = 0; i < 6; i++) step(1, DW'(16'h7000 + i), 0, 0, 0);
    step(1, 16'h7777, 0, 0, 0);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk_reset();
    we = 1; data_in = 16'h1111;
    @(posedge clk);
    #1;
    chk_reset();
    rst = 0;
    step(1, 16'h2468, 0, 0, 0);
    chk("post_rst", 32'(data_out), 32'h2468);
    step(1, 16'h1357, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
